// File: rtl/simple_isa_pkg.sv
// rtl/simple_isa_pkg.sv - SIMPLE ISA op classes, sub-op codes and field positions
package simple_isa_pkg;

    localparam int REG_AW = 3;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_IMM = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    localparam reg_idx_t IMM_LI = 3'b000;

    localparam int F_OP_LO  = 14;
    localparam int F_RA_LO  = 11;
    localparam int F_RB_LO  = 8;
    localparam int F_OP3_LO = 4;

endpackage

// File: rtl/instr_regdecode.sv
// rtl/instr_regdecode.sv - combinational register read/write decode of a 16-bit command
module instr_regdecode
    import simple_isa_pkg::*;
(
    input  logic [15:0] in_cmd,
    output logic        rd_a_en,
    output reg_idx_t    rd_a,
    output logic        rd_b_en,
    output reg_idx_t    rd_b,
    output logic        wr_en,
    output reg_idx_t    wr_idx,
    output logic        is_load
);

    logic [1:0] op;
    logic [3:0] op3;
    reg_idx_t   ra;
    reg_idx_t   rb;
    logic       unused_lsbs;

    assign op  = in_cmd[F_OP_LO +: 2];
    assign ra  = in_cmd[F_RA_LO +: REG_AW];
    assign rb  = in_cmd[F_RB_LO +: REG_AW];
    assign op3 = in_cmd[F_OP3_LO +: 4];
    assign unused_lsbs = ^in_cmd[3:0];

    always_comb begin
        rd_a_en = 1'b0;
        rd_a    = ra;
        rd_b_en = 1'b0;
        rd_b    = rb;
        wr_en   = 1'b0;
        wr_idx  = rb;
        is_load = 1'b0;
        unique case (op)
            OP_ALU: begin
                rd_a_en = 1'b1;
                rd_b_en = 1'b1;
                wr_en   = !(op3 == OP3_CMP || op3 == OP3_OUT || op3 == OP3_HLT);
            end
            OP_LD: begin
                rd_b_en = 1'b1;
                wr_en   = 1'b1;
                wr_idx  = ra;
                is_load = 1'b1;
            end
            OP_ST: begin
                rd_a_en = 1'b1;
                rd_b_en = 1'b1;
            end
            OP_IMM: begin
                wr_en = (ra == IMM_LI);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stall_scoreboard.sv
// rtl/stall_scoreboard.sv - load-use stall scoreboard in front of execute; STALL_STATS_EN enables stall_cnt
module stall_scoreboard
    import simple_isa_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_N    = 8,
    parameter int LOAD_LAT = 2,
    parameter int ALU_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_cmd,
    output logic              in_ready,
    output logic              pnu,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_cmd,
    output logic [15:0]       stall_cnt
);

    localparam int MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] ALU_INIT  = CW'(ALU_LAT - 1);

    logic          rd_a_en;
    logic          rd_b_en;
    logic          wr_en;
    logic          is_load;
    reg_idx_t      rd_a;
    reg_idx_t      rd_b;
    reg_idx_t      wr_idx;
    logic          hazard;
    logic          accept;
    logic [CW-1:0] wr_init;
    logic [CW-1:0] cnt_q [REG_N];

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - CW'(1);
    endfunction

    instr_regdecode u_regdecode (
        .in_cmd  (in_cmd[15:0]),
        .rd_a_en (rd_a_en),
        .rd_a    (rd_a),
        .rd_b_en (rd_b_en),
        .rd_b    (rd_b),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .is_load (is_load)
    );

    // Hazard only looks at registered counters, so nothing loops back from inputs.
    always_comb begin
        hazard = 1'b0;
        if (rd_a_en && int'(rd_a) < REG_N && cnt_q[rd_a] != '0) hazard = 1'b1;
        if (rd_b_en && int'(rd_b) < REG_N && cnt_q[rd_b] != '0) hazard = 1'b1;
    end

    assign in_ready = !hold && !flush && !hazard;
    assign accept   = in_valid && in_ready;
    assign pnu      = in_valid && hazard;
    assign wr_init  = is_load ? LOAD_INIT : ALU_INIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) cnt_q[i] <= '0;
            out_valid <= 1'b0;
            out_cmd   <= '0;
        end else if (flush) begin
            for (int i = 0; i < REG_N; i++) cnt_q[i] <= '0;
            out_valid <= 1'b0;
        end else if (!hold) begin
            for (int i = 0; i < REG_N; i++) begin
                // A new write never shortens an older pending write to the same register.
                if (accept && wr_en && int'(wr_idx) == i)
                    cnt_q[i] <= (sat_dec(cnt_q[i]) > wr_init) ? sat_dec(cnt_q[i]) : wr_init;
                else
                    cnt_q[i] <= sat_dec(cnt_q[i]);
            end
            out_valid <= accept;
            if (accept) out_cmd <= in_cmd;
        end
    end

`ifdef STALL_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (in_valid && hazard && !hold && !flush && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_stall_scoreboard.sv
// tb/tb_stall_scoreboard.sv - directed self-checking bench for stall_scoreboard
module tb_stall_scoreboard;

    localparam logic [15:0] LD_R7   = 16'h3D00;
    localparam logic [15:0] ADD_R7  = 16'hF900;
    localparam logic [15:0] AND_IND = 16'hEE20;
    localparam logic [15:0] LD_R3   = 16'h1800;
    localparam logic [15:0] ST_R3   = 16'h5B00;
    localparam logic [15:0] LD_R2   = 16'h1000;
    localparam logic [15:0] ADD_R2  = 16'hD300;
    localparam logic [15:0] LD_R4   = 16'h2000;
    localparam logic [15:0] ST_R4   = 16'h6400;
`ifdef STALL_STATS_EN
    localparam logic [15:0] EXP_HOLD_STALLS = 16'd1;
`else
    localparam logic [15:0] EXP_HOLD_STALLS = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_cmd = '0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;

    logic        in_ready, pnu, out_valid;
    logic [15:0] out_cmd, stall_cnt;
    logic        in_ready3, pnu3, out_valid3;
    logic [15:0] out_cmd3, stall_cnt3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    stall_scoreboard #(.DATA_W(16), .REG_N(8), .LOAD_LAT(2), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cmd(in_cmd),
        .in_ready(in_ready), .pnu(pnu), .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_cmd(out_cmd), .stall_cnt(stall_cnt)
    );

    stall_scoreboard #(.DATA_W(16), .REG_N(8), .LOAD_LAT(3), .ALU_LAT(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cmd(in_cmd),
        .in_ready(in_ready3), .pnu(pnu3), .hold(hold), .flush(flush),
        .out_valid(out_valid3), .out_cmd(out_cmd3), .stall_cnt(stall_cnt3)
    );

    task automatic drive(input logic v, input logic [15:0] c, input logic h, input logic f);
        @(negedge clk);
        in_valid = v;
        in_cmd   = c;
        hold     = h;
        flush    = f;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; hold = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++;
        if (out_cmd !== 16'h0000) begin tests_failed++; $display("FAIL reset_out_cmd: got %h want 0000", out_cmd); end
        tests_run++;
        if (stall_cnt !== 16'h0000) begin tests_failed++; $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt); end
        tests_run++;
        if (in_ready !== 1'b1 || pnu !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_pnu: got %b/%b want 1/0", in_ready, pnu); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, LD_R7, 1'b0, 1'b0);
        tests_run++;
        if (in_ready !== 1'b1 || pnu !== 1'b0) begin tests_failed++; $display("FAIL lu_ld_ready: got rdy=%b pnu=%b want 1/0", in_ready, pnu); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b1 || out_cmd !== LD_R7) begin tests_failed++; $display("FAIL lu_ld_out: got %b/%h want 1/%h", out_valid, out_cmd, LD_R7); end
        drive(1'b1, ADD_R7, 1'b0, 1'b0);
        tests_run++;
        if (pnu !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL lu_stall: got pnu=%b rdy=%b want 1/0", pnu, in_ready); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b0 || out_cmd !== LD_R7) begin tests_failed++; $display("FAIL lu_bubble: got %b/%h want 0/%h", out_valid, out_cmd, LD_R7); end
        drive(1'b1, ADD_R7, 1'b0, 1'b0);
        tests_run++;
        if (pnu !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL lu_release: got pnu=%b rdy=%b want 0/1", pnu, in_ready); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b1 || out_cmd !== ADD_R7) begin tests_failed++; $display("FAIL lu_add_out: got %b/%h want 1/%h", out_valid, out_cmd, ADD_R7); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, LD_R7, 1'b0, 1'b0);
        after_edge();
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_first: got %b want 1", out_valid); end
        drive(1'b1, AND_IND, 1'b0, 1'b0);
        tests_run++;
        if (pnu !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_nostall: got pnu=%b rdy=%b want 0/1", pnu, in_ready); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b1 || out_cmd !== AND_IND) begin tests_failed++; $display("FAIL b2b_second: got %b/%h want 1/%h", out_valid, out_cmd, AND_IND); end
        drive(1'b0, '0, 1'b0, 1'b0);
        after_edge();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_load_lat3();
        do_reset();
        drive(1'b1, LD_R3, 1'b0, 1'b0);
        tests_run++;
        if (in_ready3 !== 1'b1) begin tests_failed++; $display("FAIL l3_ld_ready: got %b want 1", in_ready3); end
        after_edge();
        drive(1'b1, ST_R3, 1'b0, 1'b0);
        tests_run++;
        if (pnu3 !== 1'b1) begin tests_failed++; $display("FAIL l3_stall1: got %b want 1", pnu3); end
        tests_run++;
        if (pnu !== 1'b1) begin tests_failed++; $display("FAIL l2_stall1: got %b want 1", pnu); end
        after_edge();
        drive(1'b1, ST_R3, 1'b0, 1'b0);
        tests_run++;
        if (pnu3 !== 1'b1 || in_ready3 !== 1'b0) begin tests_failed++; $display("FAIL l3_stall2: got pnu=%b rdy=%b want 1/0", pnu3, in_ready3); end
        tests_run++;
        if (pnu !== 1'b0) begin tests_failed++; $display("FAIL l2_one_bubble: got %b want 0", pnu); end
        after_edge();
        drive(1'b1, ST_R3, 1'b0, 1'b0);
        tests_run++;
        if (pnu3 !== 1'b0 || in_ready3 !== 1'b1) begin tests_failed++; $display("FAIL l3_release: got pnu=%b rdy=%b want 0/1", pnu3, in_ready3); end
        after_edge();
        tests_run++;
        if (out_valid3 !== 1'b1 || out_cmd3 !== ST_R3) begin tests_failed++; $display("FAIL l3_out: got %b/%h want 1/%h", out_valid3, out_cmd3, ST_R3); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, LD_R2, 1'b0, 1'b0);
        after_edge();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ADD_R2, 1'b1, 1'b0);
            tests_run++;
            if (in_ready !== 1'b0 || pnu !== 1'b1) begin tests_failed++; $display("FAIL hold_cycle%0d: got rdy=%b pnu=%b want 0/1", k, in_ready, pnu); end
            after_edge();
            tests_run++;
            if (out_valid !== 1'b1 || out_cmd !== LD_R2) begin tests_failed++; $display("FAIL hold_frozen%0d: got %b/%h want 1/%h", k, out_valid, out_cmd, LD_R2); end
        end
        drive(1'b1, ADD_R2, 1'b0, 1'b0);
        tests_run++;
        if (pnu !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_still_stall: got pnu=%b rdy=%b want 1/0", pnu, in_ready); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_bubble: got %b want 0", out_valid); end
        drive(1'b1, ADD_R2, 1'b0, 1'b0);
        tests_run++;
        if (pnu !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_release: got pnu=%b rdy=%b want 0/1", pnu, in_ready); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b1 || out_cmd !== ADD_R2) begin tests_failed++; $display("FAIL hold_accept: got %b/%h want 1/%h", out_valid, out_cmd, ADD_R2); end
        tests_run++;
        if (stall_cnt !== EXP_HOLD_STALLS) begin tests_failed++; $display("FAIL hold_stall_cnt: got %0d want %0d", stall_cnt, EXP_HOLD_STALLS); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, LD_R4, 1'b0, 1'b0);
        after_edge();
        drive(1'b1, ST_R4, 1'b0, 1'b1);
        tests_run++;
        if (in_ready !== 1'b0 || pnu !== 1'b1) begin tests_failed++; $display("FAIL flush_block: got rdy=%b pnu=%b want 0/1", in_ready, pnu); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        drive(1'b1, ST_R4, 1'b0, 1'b0);
        tests_run++;
        if (pnu !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_cleared: got pnu=%b rdy=%b want 0/1", pnu, in_ready); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b1 || out_cmd !== ST_R4) begin tests_failed++; $display("FAIL flush_accept: got %b/%h want 1/%h", out_valid, out_cmd, ST_R4); end
        tests_run++;
        if (stall_cnt !== 16'h0000) begin tests_failed++; $display("FAIL flush_stall_cnt: got %0d want 0", stall_cnt); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, LD_R7, 1'b0, 1'b0);
        after_edge();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_cmd !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_out: got %b/%h want 0/0000", out_valid, out_cmd); end
        tests_run++;
        if (stall_cnt !== 16'h0000) begin tests_failed++; $display("FAIL rstmid_stall_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, ADD_R7, 1'b0, 1'b0);
        tests_run++;
        if (pnu !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_nostall: got pnu=%b rdy=%b want 0/1", pnu, in_ready); end
        after_edge();
        tests_run++;
        if (out_valid !== 1'b1 || out_cmd !== ADD_R7) begin tests_failed++; $display("FAIL rstmid_accept: got %b/%h want 1/%h", out_valid, out_cmd, ADD_R7); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_load_lat3();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stall_scoreboard.md
# stall_scoreboard

Parametrised, clocked successor to the combinational load-use stall judge of the SIMPLE pipeline. Sits between the fetch/decode register and the execute stage: decodes each incoming 16-bit command's source/destination registers, tracks per-register result-ready countdowns for in-flight writes, and stalls dependent commands until their operands are forwardable. Supports configurable load/ALU result latencies, downstream freeze, and pipeline flush.

## Interface
- DATA_W, 16: command width (field positions fixed for 16; larger widths zero-extend upper bits, ignored)
- REG_N, 8: architectural register count; REG_AW = $clog2(REG_N) = 3
- LOAD_LAT, 2: cycles from LD issue until its result is forwardable (≥1)
- ALU_LAT, 1: cycles from arithmetic issue until its result is forwardable (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage presents a command
- in_cmd  in  DATA_W  command word
- in_ready  out  1  command accepted this cycle (combinational)
- pnu  out  1  pipeline-not-update: in_valid && hazard (combinational)
- hold  in  1  downstream freeze; nothing accepted, scoreboard frozen
- flush  in  1  synchronous; discards current command and all pending state
- out_valid  out  1  registered: accepted command in execute-stage register
- out_cmd  out  DATA_W  registered accepted command
- stall_cnt  out  16  stall-cycle counter (see Configuration)

## Operation
- Decode (op = cmd[15:14], Ra = cmd[13:11], Rb = cmd[10:8], op3 = cmd[7:4]):
  - 11 arithmetic: reads Ra, Rb; writes Rb unless op3 ∈ {0101 CMP, 1101 OUT, 1111 HLT}; latency ALU_LAT
  - 00 LD: reads Rb; writes Ra; latency LOAD_LAT
  - 01 ST: reads Ra, Rb; no write
  - 10: cmd[13:11]=000 (LI) writes Rb, reads none, latency ALU_LAT; all others read/write none
- Scoreboard: REG_N counters, width $clog2(max(LOAD_LAT,ALU_LAT)); value = cycles until forwardable.
- hazard = any read register has counter ≠ 0.
- in_ready = !hold && !flush && !hazard. Accept = in_valid && in_ready.
- On accept with a write to Rd: counter[Rd] ← max(counter[Rd]−1, LAT−1) (conservative WAW); latency 1 yields 0, i.e. never stalls.
- Every other non-zero counter decrements by 1 per edge unless hold; hold freezes all counters and out_* registers.
- out_valid ← accept; out_cmd ← in_cmd on accept (held otherwise; out_valid drops to 0 on non-accept, non-hold cycles).
- flush (priority over hold): all counters ← 0, out_valid ← 0, current command not accepted.
- Reset: all counters 0, out_valid 0, out_cmd 0, stall_cnt 0. Reset mid-operation discards pending countdowns.

## Timing
- pnu/in_ready combinational from in_cmd, hold, flush and registered counters; no input-to-register combinational loop.
- LD accepted cycle t, LOAD_LAT=2: dependent command at t+1 sees counter 1 → pnu=1; accepted at t+2 (one bubble). LOAD_LAT=3 → two bubbles.
- Independent command following LD: accepted t+1, no stall.
- Accepted command appears on out_valid/out_cmd one cycle after acceptance.
- hold for k cycles extends any stall by exactly k cycles.

## Configuration
- STALL_STATS_EN defined: stall_cnt increments each cycle with in_valid && hazard && !hold && !flush; saturates at 16'hFFFF; cleared by reset only.
- Undefined: counter logic absent, stall_cnt tied to 16'h0000 (port retained).

## Structure
- Package simple_isa_pkg: op-class constants (OP_LD, OP_ST, OP_IMM, OP_ALU), op3 constants (CMP, OUT, HLT), LI sub-op, field bit positions, typedef reg_idx_t.
- Sub-module instr_regdecode: combinational; in_cmd → rd_a_en, rd_a, rd_b_en, rd_b, wr_en, wr_idx, is_load. Reused by forwarding logic later.

## Test plan
- LD 00_111_101_00000000 accepted, then ADD 11_111_001_0000_0000 (reads r7) → pnu=1 one cycle, accepted next cycle; out_valid sequence 1,0,1.
- LD r7 then AND 11_101_110_0010_0000 (no r7) → no stall, back-to-back out_valid 1,1.
- LOAD_LAT=3 build: LD r3 then ST reading r3 → pnu=1 for exactly two cycles.
- LD r2 then dependent ADD with hold=1 for 3 cycles at t+1 → counter frozen; acceptance at t+5; stall_cnt (STALL_STATS_EN) = 1.
- LD r4, next cycle flush with dependent command → no accept, counters cleared; same command next cycle accepted with pnu=0.
- Assert rst_n low mid-countdown → out_valid=0, stall_cnt=0 immediately; after release dependent command accepted without stall.
